// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Drives the program counter into the DataPath. The DataPath computes the
//   candidate next pc combinationally from the current pc. This block accepts
//   that candidate one update at a time and tracks run time and retired
//   updates with saturating counters. It also stops the machine when the
//   program sits on a self-loop (HALT) or, optionally, jumps to a misaligned
//   address (FAULT).
//
// Parameters:
//   RESET_VECTOR  - pc value loaded at reset and held while IDLE.
//   LOOP_LIMIT    - number of consecutive self-loop updates that halt the
//                   block (1..255).
//
// Ports:
//   clk           in   1   sole clock, rising edge
//   rst           in   1   synchronous active-low reset
//   step_en       in   1   run enable; 0 pauses sequencing
//   stall         in   1   DataPath not ready; holds pc (beats step_en)
//   pc_next       in   32  next pc from DataPath
//   pc            out  32  current program counter
//   pc_valid      out  1   high while in RUN
//   halted        out  1   high in HALT
//   fault         out  1   high in FAULT
//   cycle_count   out  32  cycles spent in RUN, saturating
//   retired_count out  32  pc updates accepted, saturating
//
// Configuration macro:
//   PC_ALIGN_CHECK_EN - when defined, an update to a pc_next whose low two
//                       bits are not zero is refused and the block enters
//                       FAULT. When undefined, the low two bits of pc_next
//                       are cleared and FAULT can never be reached.
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned LOOP_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_en,
  input  logic        stall,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0]  LOOP_LIMIT_B = 8'(LOOP_LIMIT);
  localparam logic [31:0] COUNT_MAX    = 32'hFFFF_FFFF;

  state_t      state;
  logic [7:0]  loop_count;

  logic [31:0] target_pc;
  logic        misaligned;
  logic        self_loop;
  logic [7:0]  loop_count_upd;
  logic [31:0] cycle_count_inc;
  logic [31:0] retired_count_inc;

  // The address an update would load. With the alignment check enabled, the
  // raw value is kept so that a misaligned jump can be detected and refused.
  // Without it, the low two bits are cleared so pc is always word-aligned.
  // The self-loop test below then compares against the masked value.
`ifdef PC_ALIGN_CHECK_EN
  assign target_pc  = pc_next;
  assign misaligned = (pc_next[1:0] != 2'b00);
`else
  assign target_pc  = pc_next & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
`endif

  // Self-loop tracking: an update that lands on the current pc extends the
  // run of loops. Any other update restarts the run. LOOP_LIMIT never
  // exceeds 255, so the HALT transition fires before the 8-bit counter
  // could wrap.
  assign self_loop      = (target_pc == pc);
  assign loop_count_upd = self_loop ? (loop_count + 8'd1) : 8'd0;

  // Saturating increments; each counter sticks at all-ones.
  assign cycle_count_inc   = (cycle_count   == COUNT_MAX) ? COUNT_MAX : cycle_count + 32'd1;
  assign retired_count_inc = (retired_count == COUNT_MAX) ? COUNT_MAX : retired_count + 32'd1;

  // Main sequencer FSM with registered status outputs.
  // The edge that leaves IDLE counts as the first RUN cycle, but it does not
  // load pc. The first address presented in RUN is therefore RESET_VECTOR.
  // In RUN, every edge adds to cycle_count, including stalled and halting
  // edges. HALT and FAULT freeze everything until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      pc            <= RESET_VECTOR;
      pc_valid      <= 1'b0;
      halted        <= 1'b0;
      cycle_count   <= '0;
      retired_count <= '0;
      loop_count    <= '0;
`ifdef PC_ALIGN_CHECK_EN
      fault         <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (step_en) begin
            state       <= ST_RUN;
            pc_valid    <= 1'b1;
            cycle_count <= cycle_count_inc;
          end
        end

        ST_RUN: begin
          cycle_count <= cycle_count_inc;
          if (!stall && step_en) begin
            if (misaligned) begin
              // Only reachable with the alignment check built in.
              // pc keeps the last good address.
              state    <= ST_FAULT;
              pc_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
              fault    <= 1'b1;
`endif
            end else begin
              pc            <= target_pc;
              retired_count <= retired_count_inc;
              loop_count    <= loop_count_upd;
              if (loop_count_upd == LOOP_LIMIT_B) begin
                state    <= ST_HALT;
                pc_valid <= 1'b0;
                halted   <= 1'b1;
              end
            end
          end
        end

        ST_HALT: begin
          state <= ST_HALT;
        end

        ST_FAULT: begin
          state <= ST_FAULT;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef PC_ALIGN_CHECK_EN
  // Without the alignment check, FAULT is unreachable and the flag is
  // constant.
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Purpose:
//   Self-checking bench for pc_sequencer. A stimulus process drives inputs on
//   the falling edge and advances a behavioural model. It then pushes the
//   outputs expected after the next rising edge into a scoreboard queue. A
//   separate monitor pops one entry per rising edge and compares it with
//   the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam int          LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_en = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc_next = '0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        halted;
  logic        fault;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;

  typedef struct {
    logic [31:0] pc;
    logic        pc_valid;
    logic        halted;
    logic        fault;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t sb_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: running/halted/faulted flags plus plain counters.
  bit          m_running = 1'b0;
  bit          m_halted  = 1'b0;
  bit          m_faulted = 1'b0;
  logic [31:0] m_pc      = RV;
  longint      m_cyc     = 0;
  longint      m_ret     = 0;
  int          m_loop    = 0;

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .LOOP_LIMIT   (LIM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .step_en       (step_en),
    .stall         (stall),
    .pc_next       (pc_next),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .halted        (halted),
    .fault         (fault),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  function automatic longint satInc(input longint x);
    return (x + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x + 1;
  endfunction

  // Advance the model by one rising edge with the given inputs.
  task automatic modelEdge(input logic r, input logic se, input logic st,
                           input logic [31:0] nxt);
    logic [31:0] newpc;
    if (!r) begin
      m_running = 1'b0;
      m_halted  = 1'b0;
      m_faulted = 1'b0;
      m_pc      = RV;
      m_cyc     = 0;
      m_ret     = 0;
      m_loop    = 0;
    end else if (m_halted || m_faulted) begin
      // frozen until reset
    end else if (!m_running) begin
      if (se) begin
        m_running = 1'b1;
        m_cyc     = satInc(m_cyc);
      end
    end else begin
      m_cyc = satInc(m_cyc);
      if (se && !st) begin
`ifdef PC_ALIGN_CHECK_EN
        if ((nxt % 32'd4) != 0) begin
          m_running = 1'b0;
          m_faulted = 1'b1;
        end else begin
          newpc = nxt;
`else
        begin
          newpc = nxt - (nxt % 32'd4);
`endif
          m_loop = (newpc == m_pc) ? m_loop + 1 : 0;
          m_pc   = newpc;
          m_ret  = satInc(m_ret);
          if (m_loop == LIM) begin
            m_running = 1'b0;
            m_halted  = 1'b1;
          end
        end
      end
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and queue what the DUT
  // must show after the following rising edge.
  task automatic applyStimulus(input logic r, input logic se, input logic st,
                               input logic [31:0] nxt);
    exp_t e;
    @(negedge clk);
    rst     = r;
    step_en = se;
    stall   = st;
    pc_next = nxt;
    modelEdge(r, se, st, nxt);
    e.pc       = m_pc;
    e.pc_valid = m_running;
    e.halted   = m_halted;
    e.fault    = m_faulted;
    e.cyc      = m_cyc[31:0];
    e.ret      = m_ret[31:0];
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (pc !== e.pc || pc_valid !== e.pc_valid || halted !== e.halted ||
        fault !== e.fault || cycle_count !== e.cyc || retired_count !== e.ret) begin
      miscompares++;
      $display("[TB] FAIL vec%0d @%0t: got pc=%h v=%b h=%b f=%b cyc=%0d ret=%0d; expected pc=%h v=%b h=%b f=%b cyc=%0d ret=%0d",
               vectors, $time, pc, pc_valid, halted, fault, cycle_count, retired_count,
               e.pc, e.pc_valid, e.halted, e.fault, e.cyc, e.ret);
    end
  endtask

  // Monitor: one DUT observation per rising edge, taken 1 unit after the
  // edge and compared against the oldest scoreboard entry.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized run.
  initial begin
    int mode;
    int guard;
    logic [31:0] nxt;

    // reset held for two edges
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);

    // straight-line execution: entry edge plus ten updates
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b1, 1'b0, m_pc + 32'd4);

    // stall beats step_en, then resume
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, m_pc + 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, m_pc + 32'd4);

    // paused by step_en
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, m_pc + 32'd4);

    // self-loop until halt, then inputs in HALT must be ignored
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, m_pc);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'(i % 2), 1'(i % 2 == 0), m_pc + 32'd4);

    // reset out of HALT, restart and climb to pc=16
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, m_pc + 32'd4);
    guard = 0;
    while (m_pc != 32'd16 && guard < 20) begin
      applyStimulus(1'b1, 1'b1, 1'b0, m_pc + 32'd4);
      guard++;
    end

    // misaligned next pc
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0022);

    // wrap through the top of the address space
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8);
    applyStimulus(1'b1, 1'b1, 1'b0, m_pc + 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, m_pc + 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, m_pc + 32'd4);

    // randomized run with occasional resets
    for (int i = 0; i < 3000; i++) begin
      mode = $urandom_range(0, 9);
      if (mode <= 5)      nxt = m_pc + 32'd4;
      else if (mode <= 7) nxt = m_pc;
      else if (mode == 8) nxt = $urandom;
      else                nxt = m_pc + 32'($urandom_range(1, 3));
      applyStimulus(1'($urandom_range(0, 63) != 0),
                    1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 3) == 0),
                    nxt);
    end

    // drain the scoreboard within a bounded number of edges
    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
